// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sequential N-word sorter
package sort_pkg;

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   localparam int SORT_WIDTH = 5;
   localparam int SORT_N     = 4;

   // Counters must reach N without wrapping
   function automatic int clog2_np1(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sort_n_seq_sort_2ip.sv
// rtl/sort_n_seq_sort_2ip.sv - combinational 2-input compare-exchange cell
module Sort_2ip
   import sort_pkg::*;
#(
   parameter int WIDTH = SORT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] l
);

   // Equal operands pass straight through, so ties never swap
   always_comb begin
      if (a > b) begin
         g = a;
         l = b;
      end else begin
         g = b;
         l = a;
      end
   end

endmodule

// File: rtl/sort_n_seq.sv
// rtl/sort_n_seq.sv - loads N words, odd-even transposition sorts them in place, streams them out ascending
module sort_n_seq
   import sort_pkg::*;
#(
   parameter int WIDTH = SORT_WIDTH,
   parameter int N     = SORT_N
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int CW = clog2_np1(N);

   state_t           state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    pass_q, pass_d;
   logic [CW-1:0]    didx_q, didx_d;
   logic [WIDTH-1:0] mem_q [N];
   logic [WIDTH-1:0] mem_d [N];
   logic [WIDTH-1:0] swap_res [N];
   logic [WIDTH-1:0] cell_g [N-1];
   logic [WIDTH-1:0] cell_l [N-1];

   // Cell i compares neighbours (i, i+1); even cells form the even bank, odd cells the odd bank
   for (genvar gi = 0; gi < N - 1; gi++) begin : g_cell
      Sort_2ip #(.WIDTH(WIDTH)) u_cell (
         .a (mem_q[gi]),
         .b (mem_q[gi+1]),
         .g (cell_g[gi]),
         .l (cell_l[gi])
      );
   end

   always_comb begin
      swap_res = mem_q;
      for (int i = 0; i < N - 1; i++) begin
         if (1'(i) == pass_q[0]) begin
            swap_res[i]   = cell_l[i];
            swap_res[i+1] = cell_g[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      didx_d  = didx_q;
      mem_d   = mem_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               for (int i = 0; i < N; i++) begin
                  if (idx_q == CW'(i)) mem_d[i] = in_data;
               end
               if (idx_q == CW'(N - 1)) begin
                  idx_d   = '0;
                  state_d = SORT;
               end else begin
                  idx_d = idx_q + CW'(1);
               end
            end
         end
         SORT: begin
            mem_d = swap_res;
            if (pass_q == CW'(N - 1)) begin
               pass_d  = '0;
               state_d = DRAIN;
            end else begin
               pass_d = pass_q + CW'(1);
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (didx_q == CW'(N - 1)) begin
                  didx_d  = '0;
                  state_d = LOAD;
               end else begin
                  didx_d = didx_q + CW'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         idx_q   <= '0;
         pass_q  <= '0;
         didx_q  <= '0;
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         didx_q  <= didx_d;
         mem_q   <= mem_d;
      end
   end

   // Outputs depend on registered state only
   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q != LOAD);

   always_comb begin
      out_data = '0;
      for (int i = 0; i < N; i++) begin
         if (didx_q == CW'(i)) out_data = mem_q[i];
      end
   end

endmodule
